x86_decode_front: RTL and testbench



---
 rtl/x86_decode_front.sv | 198 +++++++++++++++++++
 tb/tb_x86_decode_front.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/x86_decode_front.sv
// x86 instruction front-end: parses prefixes, opcode, ModRM, SIB and displacement
// from a byte stream and presents one decoded header per instruction.
module x86_decode_front #(
  parameter int unsigned MAX_LEN  = 15,
  parameter int unsigned MODRM_0F = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        cs_d,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_opcode,
  output logic        out_opsize,
  output logic        out_adsize,
  output logic        out_lock,
  output logic [1:0]  out_rep,
  output logic        out_segment_of,
  output logic [2:0]  out_segment_id,
  output logic        out_has_modrm,
  output logic        out_has_sib,
  output logic [7:0]  out_modrm,
  output logic [7:0]  out_sib,
  output logic [31:0] out_disp,
  output logic [3:0]  out_length,
  output logic        out_error
);

  typedef enum logic [2:0] {PREFIX, OP2, MODRM, SIB, DISP, DONE} state_t;

  localparam logic [3:0] MAXL = 4'(MAX_LEN);

  state_t     state, nstate;
  logic [3:0] cnt;
  logic [2:0] dsz, ndsz;
  logic [1:0] didx;
  logic       opflag, adflag, opflag_n, adflag_n;
  logic       ad32, acc;
  logic [1:0] mod;

  function automatic logic modrm_1b(input logic [7:0] op);
    logic r;
    r = (op[7:6] == 2'b00) && !op[2];
    case (op) inside
      8'h62, 8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1, [8'hC4:8'hC7],
      [8'hD0:8'hD3], [8'hD8:8'hDF], 8'hF6, 8'hF7, 8'hFE, 8'hFF: r = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic modrm_2b(input logic [7:0] op);
    logic r;
    r = (MODRM_0F != 0);
    case (op) inside
      8'h06, 8'h08, 8'h09, 8'h0B, [8'h30:8'h37], [8'h80:8'h8F],
      8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hA9, [8'hC8:8'hCF]: r = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  assign in_ready = !reset && (state != DONE);
  assign acc      = in_valid && in_ready;
  assign ad32     = cs_d ^ adflag;
  assign mod      = out_modrm[7:6];

  always_comb begin
    nstate   = state;
    ndsz     = dsz;
    opflag_n = opflag | ((state == PREFIX) && (in_data == 8'h66));
    adflag_n = adflag | ((state == PREFIX) && (in_data == 8'h67));
    case (state)
      PREFIX: begin
        case (in_data) inside
          8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67,
          8'hF0, 8'hF2, 8'hF3: nstate = PREFIX;
          8'h0F:               nstate = OP2;
          default:             nstate = modrm_1b(in_data) ? MODRM : DONE;
        endcase
      end
      OP2: nstate = modrm_2b(in_data) ? MODRM : DONE;
      MODRM: begin
        nstate = DISP;
        if (in_data[7:6] == 2'b11) nstate = DONE;
        else if (ad32) begin
          if (in_data[2:0] == 3'b100)                              nstate = SIB;
          else if (in_data[7:6] == 2'b00 && in_data[2:0] == 3'b101) ndsz = 3'd4;
          else if (in_data[7:6] == 2'b01)                          ndsz = 3'd1;
          else if (in_data[7:6] == 2'b10)                          ndsz = 3'd4;
          else                                                     nstate = DONE;
        end else begin
          if (in_data[7:6] == 2'b00 && in_data[2:0] == 3'b110) ndsz = 3'd2;
          else if (in_data[7:6] == 2'b01)                      ndsz = 3'd1;
          else if (in_data[7:6] == 2'b10)                      ndsz = 3'd2;
          else                                                 nstate = DONE;
        end
      end
      SIB: begin
        nstate = DISP;
        if (in_data[2:0] == 3'b101 && mod == 2'b00) ndsz = 3'd4;
        else if (mod == 2'b01)                      ndsz = 3'd1;
        else if (mod == 2'b10)                      ndsz = 3'd4;
        else                                        nstate = DONE;
      end
      DISP:    nstate = ({1'b0, didx} == dsz - 3'd1) ? DONE : DISP;
      default: nstate = DONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush || (state == DONE && out_ready)) begin
      state          <= PREFIX;
      cnt            <= '0;
      dsz            <= '0;
      didx           <= '0;
      opflag         <= 1'b0;
      adflag         <= 1'b0;
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_opsize     <= 1'b0;
      out_adsize     <= 1'b0;
      out_lock       <= 1'b0;
      out_rep        <= '0;
      out_segment_of <= 1'b0;
      out_segment_id <= '0;
      out_has_modrm  <= 1'b0;
      out_has_sib    <= 1'b0;
      out_modrm      <= '0;
      out_sib        <= '0;
      out_disp       <= '0;
      out_length     <= '0;
      out_error      <= 1'b0;
    end else if (acc) begin
      cnt        <= cnt + 4'd1;
      out_length <= cnt + 4'd1;
      opflag     <= opflag_n;
      adflag     <= adflag_n;
      out_opsize <= cs_d ^ opflag_n;
      out_adsize <= cs_d ^ adflag_n;
      dsz        <= ndsz;
      case (state)
        PREFIX: begin
          case (in_data) inside
            8'h26, 8'h2E, 8'h36, 8'h3E: begin
              out_segment_of <= 1'b1;
              out_segment_id <= {1'b0, in_data[4:3]};
            end
            8'h64, 8'h65: begin
              out_segment_of <= 1'b1;
              out_segment_id <= {2'b10, in_data[0]};
            end
            8'hF0:                      out_lock <= 1'b1;
            8'hF2, 8'hF3:               out_rep  <= {1'b1, in_data[0]};
            8'h66, 8'h67, 8'h0F: ;
            default:                    out_opcode <= {1'b0, in_data};
          endcase
        end
        OP2: out_opcode <= {1'b1, in_data};
        MODRM: begin
          out_has_modrm <= 1'b1;
          out_modrm     <= in_data;
        end
        SIB: begin
          out_has_sib <= 1'b1;
          out_sib     <= in_data;
        end
        DISP: begin
          didx <= didx + 2'd1;
          // disp8/disp16 sign-extend as their last byte lands; disp32 fills in place
          case (dsz)
            3'd1: out_disp <= {{24{in_data[7]}}, in_data};
            3'd2: begin
              if (didx == 2'd0) out_disp[7:0]  <= in_data;
              else              out_disp[31:8] <= {{16{in_data[7]}}, in_data};
            end
            default: out_disp[{didx, 3'b000} +: 8] <= in_data;
          endcase
        end
        default: ;
      endcase
      if (nstate == DONE) begin
        state     <= DONE;
        out_valid <= 1'b1;
      end else if (cnt + 4'd1 == MAXL) begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_error <= 1'b1;
      end else begin
        state <= nstate;
      end
    end
  end

endmodule

// File: tb/tb_x86_decode_front.sv
// Directed bench for x86_decode_front: table of instructions with expected
// headers, plus sequences for stall, length limit, flush and reset.
module tb_x86_decode_front;

  logic        clock = 1'b0;
  logic        reset, flush, cs_d, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [8:0]  out_opcode;
  logic        out_opsize, out_adsize, out_lock, out_segment_of;
  logic [1:0]  out_rep;
  logic [2:0]  out_segment_id;
  logic        out_has_modrm, out_has_sib, out_error;
  logic [7:0]  out_modrm, out_sib;
  logic [31:0] out_disp;
  logic [3:0]  out_length;

  int errors = 0;
  int checks = 0;

  x86_decode_front #(.MAX_LEN(15), .MODRM_0F(1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .cs_d(cs_d),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_opsize(out_opsize), .out_adsize(out_adsize),
    .out_lock(out_lock), .out_rep(out_rep),
    .out_segment_of(out_segment_of), .out_segment_id(out_segment_id),
    .out_has_modrm(out_has_modrm), .out_has_sib(out_has_sib),
    .out_modrm(out_modrm), .out_sib(out_sib), .out_disp(out_disp),
    .out_length(out_length), .out_error(out_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] bytes;   // first byte in bits 63:56
    int          n;
    logic        cs;
    logic [8:0]  op;
    logic [3:0]  len;
    logic        hm;
    logic [7:0]  modrm;
    logic        hs;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic        os;
    logic        as;
    logic        lk;
    logic [1:0]  rep;
    logic        sof;
    logic [2:0]  sid;
    logic        err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  task automatic take;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] bb;
    vt[0] = '{64'h9000000000000000, 1, 1'b0, 9'h090, 4'd1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,
              1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[1] = '{64'h66662664F3F0A500, 7, 1'b0, 9'h0A5, 4'd7, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,
              1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 3'd4, 1'b0};
    vt[2] = '{64'h8B4424F800000000, 4, 1'b1, 9'h08B, 4'd4, 1'b1, 8'h44, 1'b1, 8'h24, 32'hFFFFFFF8,
              1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[3] = '{64'h8B86341200000000, 4, 1'b0, 9'h08B, 4'd4, 1'b1, 8'h86, 1'b0, 8'h00, 32'h00001234,
              1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[4] = '{64'h0FAFC30000000000, 3, 1'b1, 9'h1AF, 4'd3, 1'b1, 8'hC3, 1'b0, 8'h00, 32'h0,
              1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[5] = '{64'h678B4424F8000000, 5, 1'b0, 9'h08B, 4'd5, 1'b1, 8'h44, 1'b1, 8'h24, 32'hFFFFFFF8,
              1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[6] = '{64'h8B05785634120000, 6, 1'b1, 9'h08B, 4'd6, 1'b1, 8'h05, 1'b0, 8'h00, 32'h12345678,
              1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[7] = '{64'h8B048D0000008000, 7, 1'b1, 9'h08B, 4'd7, 1'b1, 8'h04, 1'b1, 8'h8D, 32'h80000000,
              1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0};
    vt[8] = '{64'h2E3E8B4680000000, 5, 1'b0, 9'h08B, 4'd5, 1'b1, 8'h46, 1'b0, 8'h00, 32'hFFFFFF80,
              1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd3, 1'b0};
    vt[9] = '{64'hF3F20F0600000000, 4, 1'b0, 9'h106, 4'd4, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,
              1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 3'd0, 1'b0};

    reset = 1'b1; flush = 1'b0; cs_d = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_opcode",    32'(out_opcode), 32'd0);
    chk("rst_length",    32'(out_length), 32'd0);
    chk("rst_disp",      out_disp, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // single-byte latency: out_valid one cycle after the byte
    @(negedge clock);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_data = 8'h90; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("lat1_valid",  32'(out_valid), 32'd1);
    chk("lat1_ready",  32'(in_ready), 32'd0);
    chk("lat1_opcode", 32'(out_opcode), 32'h090);
    take();
    chk("bubble_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      cs_d = vt[i].cs;
      bb = vt[i].bytes;
      for (int k = 0; k < vt[i].n; k++) send(bb[63 - 8*k -: 8]);
      wait_out($sformatf("v%0d_valid", i));
      chk($sformatf("v%0d_opcode", i), 32'(out_opcode),     32'(vt[i].op));
      chk($sformatf("v%0d_length", i), 32'(out_length),     32'(vt[i].len));
      chk($sformatf("v%0d_hmodrm", i), 32'(out_has_modrm),  32'(vt[i].hm));
      chk($sformatf("v%0d_modrm", i),  32'(out_modrm),      32'(vt[i].modrm));
      chk($sformatf("v%0d_hsib", i),   32'(out_has_sib),    32'(vt[i].hs));
      chk($sformatf("v%0d_sib", i),    32'(out_sib),        32'(vt[i].sib));
      chk($sformatf("v%0d_disp", i),   out_disp,            vt[i].disp);
      chk($sformatf("v%0d_opsize", i), 32'(out_opsize),     32'(vt[i].os));
      chk($sformatf("v%0d_adsize", i), 32'(out_adsize),     32'(vt[i].as));
      chk($sformatf("v%0d_lock", i),   32'(out_lock),       32'(vt[i].lk));
      chk($sformatf("v%0d_rep", i),    32'(out_rep),        32'(vt[i].rep));
      chk($sformatf("v%0d_segof", i),  32'(out_segment_of), 32'(vt[i].sof));
      chk($sformatf("v%0d_segid", i),  32'(out_segment_id), 32'(vt[i].sid));
      chk($sformatf("v%0d_error", i),  32'(out_error),      32'(vt[i].err));
      take();
    end

    // header held stable while the consumer stalls
    cs_d = 1'b0;
    send(8'h0F); send(8'h84);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("hold_valid",  32'(out_valid), 32'd1);
      chk("hold_opcode", 32'(out_opcode), 32'h184);
      chk("hold_modrm",  32'(out_has_modrm), 32'd0);
      chk("hold_ready",  32'(in_ready), 32'd0);
      chk("hold_length", 32'(out_length), 32'd2);
    end
    take();

    // length limit: fifteen 66 prefixes, then 90 decodes on its own
    for (int k = 0; k < 15; k++) send(8'h66);
    #1;
    chk("lim_valid",  32'(out_valid), 32'd1);
    chk("lim_error",  32'(out_error), 32'd1);
    chk("lim_length", 32'(out_length), 32'd15);
    chk("lim_opsize", 32'(out_opsize), 32'd1);
    take();
    send(8'h90);
    wait_out("lim_next_valid");
    chk("lim_next_error",  32'(out_error), 32'd0);
    chk("lim_next_length", 32'(out_length), 32'd1);
    chk("lim_next_opsize", 32'(out_opsize), 32'd0);
    take();

    // flush in the middle of a disp32
    cs_d = 1'b1;
    send(8'h8B); send(8'h05); send(8'h78); send(8'h56);
    @(negedge clock);
    flush = 1'b1; in_data = 8'h34; in_valid = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("flush_valid", 32'(out_valid), 32'd0);
    end
    send(8'h90);
    wait_out("flush_next_valid");
    chk("flush_next_length", 32'(out_length), 32'd1);
    chk("flush_next_modrm",  32'(out_has_modrm), 32'd0);
    chk("flush_next_disp",   out_disp, 32'd0);
    chk("flush_next_opcode", 32'(out_opcode), 32'h090);
    take();

    // reset in the middle of prefixes
    send(8'h66); send(8'hF0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mrst_in_ready",  32'(in_ready), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    send(8'h90);
    wait_out("mrst_next_valid");
    chk("mrst_next_length", 32'(out_length), 32'd1);
    chk("mrst_next_lock",   32'(out_lock), 32'd0);
    chk("mrst_next_opsize", 32'(out_opsize), 32'd1);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
